// File: rtl/multi_candidate_voting_machine.sv
// N-candidate voting core: edge-detected presses, saturating tallies, open/close FSM and winner scan.
// Optional post-vote lockout window is enabled by defining VOTE_LOCKOUT_EN.
module multi_candidate_voting_machine #(
    parameter int N_CAND         = 4,
    parameter int COUNT_W        = 8,
    parameter int LOCKOUT_CYCLES = 4,
    localparam int WIN_W         = $clog2(N_CAND)
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        start,
    input  logic                        close,
    input  logic [N_CAND-1:0]           vote,
    output logic [N_CAND*COUNT_W-1:0]   counts,
    output logic [COUNT_W-1:0]          total,
    output logic [COUNT_W-1:0]          invalid,
    output logic [1:0]                  state,
    output logic [WIN_W-1:0]            winner,
    output logic                        tie,
    output logic                        result_valid,
    output logic                        locked
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_OPEN  = 2'd1,
        S_TALLY = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [COUNT_W-1:0] SAT = '1;

    state_t             r_state;
    state_t             w_state_next;
    logic [N_CAND-1:0]  r_vote_q;
    logic [COUNT_W-1:0] r_counts [N_CAND];
    logic [COUNT_W-1:0] r_total;
    logic [COUNT_W-1:0] r_invalid;
    logic [COUNT_W-1:0] r_max;
    logic [WIN_W-1:0]   r_winner;
    logic [WIN_W-1:0]   r_scan_idx;
    logic               r_tie;

    logic               w_press_any;
    logic               w_single;
    logic               w_eligible;
    logic               w_start_ok;
    logic               w_close_ok;
    logic               w_scan_last;
    logic               w_locked;
    logic [COUNT_W-1:0] w_scan_cnt;

    assign w_press_any = |(vote & ~r_vote_q);
    // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
    assign w_single    = (vote != '0) && ((vote & (vote - N_CAND'(1))) == '0);
    assign w_eligible  = (r_state == S_OPEN) && w_press_any && !w_locked;
    assign w_start_ok  = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_close_ok  = close && (r_state == S_OPEN);
    assign w_scan_last = (r_scan_idx == WIN_W'(N_CAND - 1));
    assign w_scan_cnt  = r_counts[r_scan_idx];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_OPEN;
            S_OPEN:  if (close) w_state_next = S_TALLY;
            S_TALLY: if (w_scan_last) w_state_next = S_DONE;
            S_DONE:  if (start) w_state_next = S_OPEN;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_vote_q   <= '0;
            r_total    <= '0;
            r_invalid  <= '0;
            r_max      <= '0;
            r_winner   <= '0;
            r_scan_idx <= '0;
            r_tie      <= 1'b0;
            for (int i = 0; i < N_CAND; i++) r_counts[i] <= '0;
        end else begin
            r_vote_q <= vote;
            if (w_start_ok) begin
                r_total   <= '0;
                r_invalid <= '0;
                r_winner  <= '0;
                r_tie     <= 1'b0;
                for (int i = 0; i < N_CAND; i++) r_counts[i] <= '0;
            end else if (w_eligible) begin
                if (w_single) begin
                    for (int i = 0; i < N_CAND; i++) begin
                        if (vote[i] && (r_counts[i] != SAT)) r_counts[i] <= r_counts[i] + COUNT_W'(1);
                    end
                    if (r_total != SAT) r_total <= r_total + COUNT_W'(1);
                end else if (r_invalid != SAT) begin
                    r_invalid <= r_invalid + COUNT_W'(1);
                end
            end
            // Scan starts from max=0; an all-zero field therefore ends with tie set and winner 0.
            if (w_close_ok) begin
                r_scan_idx <= '0;
                r_max      <= '0;
                r_winner   <= '0;
                r_tie      <= 1'b0;
            end else if (r_state == S_TALLY) begin
                if (w_scan_cnt > r_max) begin
                    r_max    <= w_scan_cnt;
                    r_winner <= r_scan_idx;
                    r_tie    <= 1'b0;
                end else if (w_scan_cnt == r_max) begin
                    r_tie <= 1'b1;
                end
                r_scan_idx <= r_scan_idx + WIN_W'(1);
            end
        end
    end

`ifdef VOTE_LOCKOUT_EN
    localparam int LK_W = $clog2(LOCKOUT_CYCLES + 1);
    logic [LK_W-1:0] r_lock_cnt;

    always_ff @(posedge clk) begin
        if (!reset_n || w_close_ok) begin
            r_lock_cnt <= '0;
        end else if (w_eligible) begin
            r_lock_cnt <= LK_W'(LOCKOUT_CYCLES);
        end else if (r_lock_cnt != '0) begin
            r_lock_cnt <= r_lock_cnt - LK_W'(1);
        end
    end

    assign w_locked = (r_lock_cnt != '0);
`else
    // No lockout in this build; the parameter is only referenced to keep it visibly used.
    assign w_locked = (LOCKOUT_CYCLES < 0);
`endif

    for (genvar g = 0; g < N_CAND; g++) begin : g_counts
        assign counts[g*COUNT_W +: COUNT_W] = r_counts[g];
    end

    assign total        = r_total;
    assign invalid      = r_invalid;
    assign state        = r_state;
    assign winner       = r_winner;
    assign tie          = r_tie;
    assign result_valid = (r_state == S_DONE);
    assign locked       = w_locked;

endmodule

// File: tb/tb_multi_candidate_voting_machine.sv
// Bench for multi_candidate_voting_machine: scoreboard of expected tallies plus direct checks
// of FSM timing, winner/tie scan, saturation (COUNT_W=4 instance), reset and lockout.
module tb_multi_candidate_voting_machine;

`ifdef VOTE_LOCKOUT_EN
    localparam int GAP = 6;
`else
    localparam int GAP = 1;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, start, close;
    logic [3:0]  vote;
    logic [31:0] counts;
    logic [7:0]  total, invalid;
    logic [1:0]  state, winner;
    logic        tie, result_valid, locked;

    logic        start4, close4;
    logic [3:0]  vote4;
    logic [15:0] counts4;
    logic [3:0]  total4, invalid4;
    logic [1:0]  state4, winner4;
    logic        tie4, rv4, locked4;

    multi_candidate_voting_machine #(.N_CAND(4), .COUNT_W(8), .LOCKOUT_CYCLES(4)) u_dut (
        .clk(clk), .reset_n(reset_n), .start(start), .close(close), .vote(vote),
        .counts(counts), .total(total), .invalid(invalid), .state(state),
        .winner(winner), .tie(tie), .result_valid(result_valid), .locked(locked)
    );

    multi_candidate_voting_machine #(.N_CAND(4), .COUNT_W(4), .LOCKOUT_CYCLES(4)) u_dut4 (
        .clk(clk), .reset_n(reset_n), .start(start4), .close(close4), .vote(vote4),
        .counts(counts4), .total(total4), .invalid(invalid4), .state(state4),
        .winner(winner4), .tie(tie4), .result_valid(rv4), .locked(locked4)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [47:0] exp_q[$];
    int          m_cnt[4];
    int          m_total, m_invalid;
    bit          m_open;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int sat8(input int v);
        return (v >= 255) ? 255 : v + 1;
    endfunction

    function automatic logic [47:0] pack_model();
        return {8'(m_cnt[3]), 8'(m_cnt[2]), 8'(m_cnt[1]), 8'(m_cnt[0]), 8'(m_total), 8'(m_invalid)};
    endfunction

    task automatic model_vote(input logic [3:0] mask);
        if (m_open && mask != 4'b0) begin
            if ($countones(mask) == 1) begin
                for (int i = 0; i < 4; i++) if (mask[i]) m_cnt[i] = sat8(m_cnt[i]);
                m_total = sat8(m_total);
            end else begin
                m_invalid = sat8(m_invalid);
            end
        end
        exp_q.push_back(pack_model());
    endtask

    task automatic compare_out(input string tag);
        logic [47:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_q_empty"}, 64'd1, 64'd0);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_counts"}, 64'(counts), 64'(e[47:16]));
            check({tag, "_total"}, 64'(total), 64'(e[15:8]));
            check({tag, "_invalid"}, 64'(invalid), 64'(e[7:0]));
        end
    endtask

    task automatic drive_vote(input logic [3:0] mask, input int hold);
        vote = mask;
        model_vote(mask);
        repeat (hold) tick();
        vote = 4'b0;
        repeat (GAP) tick();
        compare_out("vote");
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        m_total = 0;
        m_invalid = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        model_clear();
        m_open = 1'b1;
        exp_q.push_back(pack_model());
        tick();
        start = 1'b0;
        compare_out("start");
        check("start_state", 64'(state), 64'd1);
        check("start_rv", 64'(result_valid), 64'd0);
        check("start_winner", 64'(winner), 64'd0);
        check("start_tie", 64'(tie), 64'd0);
    endtask

    // Close with start asserted alongside (start must be ignored in OPEN) and a vote in the close cycle.
    task automatic close_scan(input logic [3:0] mask);
        int mx, w, nt;
        vote  = mask;
        close = 1'b1;
        start = 1'b1;
        model_vote(mask);
        m_open = 1'b0;
        tick();
        vote  = 4'b0;
        close = 1'b0;
        start = 1'b0;
        compare_out("close");
        for (int k = 0; k < 4; k++) begin
            check("tally_state", 64'(state), 64'd2);
            check("tally_rv", 64'(result_valid), 64'd0);
            tick();
        end
        mx = -1; w = 0; nt = 0;
        for (int i = 0; i < 4; i++) begin
            if (m_cnt[i] > mx) begin
                mx = m_cnt[i]; w = i; nt = 1;
            end else if (m_cnt[i] == mx) begin
                nt++;
            end
        end
        check("done_state", 64'(state), 64'd3);
        check("done_rv", 64'(result_valid), 64'd1);
        check("done_winner", 64'(winner), 64'(w));
        check("done_tie", 64'(tie), 64'(nt >= 2));
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; close = 1'b0; vote = 4'b0;
        start4 = 1'b0; close4 = 1'b0; vote4 = 4'b0;
        model_clear();
        m_open = 1'b0;
        repeat (2) tick();
        check("rst_state", 64'(state), 64'd0);
        check("rst_counts", 64'(counts), 64'd0);
        check("rst_total", 64'(total), 64'd0);
        check("rst_invalid", 64'(invalid), 64'd0);
        check("rst_winner", 64'(winner), 64'd0);
        check("rst_tie", 64'(tie), 64'd0);
        check("rst_rv", 64'(result_valid), 64'd0);
        check("rst_locked", 64'(locked), 64'd0);
        reset_n = 1'b1;
        tick();

        drive_vote(4'b0010, 1);
        check("idle_press_state", 64'(state), 64'd0);

        pulse_start();
        drive_vote(4'b0100, 1);
        drive_vote(4'b0001, 1);
        drive_vote(4'b0100, 1);
        drive_vote(4'b1000, 1);
        check("t1_counts", 64'(counts), 64'h01_02_00_01);
        check("t1_total", 64'(total), 64'd4);

        drive_vote(4'b0011, 1);
        check("t2_invalid", 64'(invalid), 64'd1);
        drive_vote(4'b0100, 10);
        check("t2_hold_counts", 64'(counts), 64'h01_03_00_01);

        close_scan(4'b1000);
        close = 1'b1;
        tick();
        close = 1'b0;
        check("done_close_ignored", 64'(state), 64'd3);

        pulse_start();
        repeat (3) drive_vote(4'b0001, 1);
        repeat (5) drive_vote(4'b0010, 1);
        repeat (5) drive_vote(4'b0100, 1);
        drive_vote(4'b1000, 1);
        close_scan(4'b0000);
        check("t3_winner", 64'(winner), 64'd1);
        check("t3_tie", 64'(tie), 64'd1);

        pulse_start();
        close_scan(4'b0000);
        check("zero_tie", 64'(tie), 64'd1);

        pulse_start();
        repeat (2) drive_vote(4'b0001, 1);
        drive_vote(4'b0010, 1);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        model_clear();
        m_open = 1'b0;
        check("t5_state", 64'(state), 64'd0);
        check("t5_counts", 64'(counts), 64'd0);
        check("t5_total", 64'(total), 64'd0);
        check("t5_rv", 64'(result_valid), 64'd0);
        drive_vote(4'b0001, 1);

`ifdef VOTE_LOCKOUT_EN
        pulse_start();
        vote = 4'b0001; tick();
        check("lk_hi0", 64'(locked), 64'd1);
        vote = 4'b0000; tick();
        check("lk_hi1", 64'(locked), 64'd1);
        vote = 4'b0010; tick();
        check("lk_hi2", 64'(locked), 64'd1);
        vote = 4'b0000; tick();
        check("lk_hi3", 64'(locked), 64'd1);
        tick();
        check("lk_lo", 64'(locked), 64'd0);
        check("lk_c0", 64'(counts[7:0]), 64'd1);
        check("lk_c1", 64'(counts[15:8]), 64'd0);
        check("lk_invalid", 64'(invalid), 64'd0);
        vote = 4'b0010; tick();
        vote = 4'b0000; tick();
        check("lk_c1_after", 64'(counts[15:8]), 64'd1);
`else
        pulse_start();
        vote = 4'b0001; tick();
        check("nolk_locked", 64'(locked), 64'd0);
        vote = 4'b0010; tick();
        vote = 4'b0000; tick();
        check("nolk_back_to_back", 64'(counts[15:0]), 64'h0101);
`endif

        start4 = 1'b1; tick(); start4 = 1'b0;
        check("t4_open", 64'(state4), 64'd1);
        repeat (17) begin
            vote4 = 4'b0010; tick();
            vote4 = 4'b0000; repeat (GAP) tick();
        end
        check("t4_c1_sat", 64'(counts4), 64'h00F0);
        check("t4_total_sat", 64'(total4), 64'd15);
        check("t4_invalid", 64'(invalid4), 64'd0);
        close4 = 1'b1; tick(); close4 = 1'b0;
        repeat (4) tick();
        check("t4_done", 64'(state4), 64'd3);
        check("t4_winner", 64'(winner4), 64'd1);
        check("t4_tie", 64'(tie4), 64'd0);
        start4 = 1'b1; tick(); start4 = 1'b0;
        check("t4_restart_counts", 64'(counts4), 64'd0);
        check("t4_restart_total", 64'(total4), 64'd0);
        check("t4_restart_state", 64'(state4), 64'd1);
        check("t4_restart_rv", 64'(rv4), 64'd0);
        check("t4_locked", 64'(locked4), 64'd0);

        check("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
